// File: rtl/dii_stream_ctrl.sv
// DII stream sequencer: buffers an instruction stream, holds the core in reset,
// then presents one word per core acknowledge, pads with NOPs and drains before done.
module dii_stream_ctrl #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned RST_CYCLES   = 10,
    parameter int unsigned DRAIN_CYCLES = 10,
    parameter logic [31:0] NOP_WORD     = 32'h1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_valid_i,
    input  logic [31:0]              load_data_i,
    output logic                     load_ready_o,
    input  logic                     start_i,
    input  logic                     clear_i,
    input  logic                     instr_ack_i,
    output logic [31:0]              instr_rdata_dii_o,
    output logic                     core_rst_n_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   instr_cnt_o
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned LW   = AW + 1;
    localparam int unsigned TMAX = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CORE_RST,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    // Load handshake: a word transfers on an edge where load_valid_i && load_ready_o.
    state_e          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   idx_q, idx_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            ovf_q, ovf_d;
    logic            mem_we;
    logic            can_load;
    logic [LW-1:0]   idx_nxt;
    logic [31:0]     mem_q [DEPTH];

    assign can_load = (state_q == S_IDLE) && (len_q < LW'(DEPTH));
    assign idx_nxt  = idx_q + LW'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        rdata_d = rdata_q;
        ovf_d   = ovf_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_valid_i) begin
                    if (can_load) begin
                        mem_we = 1'b1;
                        len_d  = len_q + LW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (start_i) begin
                    state_d = S_CORE_RST;
                    idx_d   = '0;
                    cnt_d   = '0;
                    tmr_d   = '0;
                end
            end
            S_CORE_RST: begin
                if (tmr_q == TW'(RST_CYCLES - 1)) begin
                    state_d = S_RUN;
                    rdata_d = (len_q == '0) ? NOP_WORD : mem_q[0];
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_RUN: begin
                // An empty stream spends exactly one cycle here presenting the NOP.
                if (len_q == '0) begin
                    state_d = S_DRAIN;
                    tmr_d   = '0;
                    rdata_d = NOP_WORD;
                end else if (instr_ack_i) begin
                    idx_d = idx_nxt;
                    cnt_d = cnt_q + LW'(1);
                    if (idx_nxt < len_q) begin
                        rdata_d = mem_q[idx_nxt[AW-1:0]];
                    end else begin
                        rdata_d = NOP_WORD;
                        state_d = S_DRAIN;
                        tmr_d   = '0;
                    end
                end
            end
            S_DRAIN: begin
                rdata_d = NOP_WORD;
                if (tmr_q == TW'(DRAIN_CYCLES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_DONE: begin
                rdata_d = NOP_WORD;
                if (clear_i) begin
                    state_d = S_IDLE;
                    len_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            rdata_q <= NOP_WORD;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
        end
    end

    // Buffer storage carries no reset; len_q alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[len_q[AW-1:0]] <= load_data_i;
        end
    end

    assign load_ready_o      = can_load;
    assign instr_rdata_dii_o = rdata_q;
    assign core_rst_n_o      = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_DONE);
    assign busy_o            = (state_q == S_CORE_RST) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o            = (state_q == S_DONE);
    assign overflow_o        = ovf_q;
    assign instr_cnt_o       = cnt_q;

endmodule

// File: tb/tb_dii_stream_ctrl.sv
// Bench for dii_stream_ctrl: directed sequence with random acks/data, checked
// against a queue-based model of the loaded stream and its run timeline.
module tb_dii_stream_ctrl;

  localparam int RST_CYC   = 10;
  localparam int DRAIN_CYC = 10;
  localparam logic [31:0] NOP = 32'h1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        load_valid_i = 1'b0;
  logic [31:0] load_data_i = '0;
  logic        start_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        instr_ack_i = 1'b0;
  logic        use_b = 1'b0;

  logic        a_ready, a_crst, a_busy, a_done, a_ovf;
  logic [31:0] a_rdata;
  logic [10:0] a_cnt;
  logic        b_ready, b_crst, b_busy, b_done, b_ovf;
  logic [31:0] b_rdata;
  logic [2:0]  b_cnt;

  dii_stream_ctrl #(.DEPTH(1024), .RST_CYCLES(RST_CYC), .DRAIN_CYCLES(DRAIN_CYC), .NOP_WORD(NOP)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .load_valid_i(load_valid_i & ~use_b), .load_data_i(load_data_i), .load_ready_o(a_ready),
    .start_i(start_i & ~use_b), .clear_i(clear_i & ~use_b), .instr_ack_i(instr_ack_i & ~use_b),
    .instr_rdata_dii_o(a_rdata), .core_rst_n_o(a_crst), .busy_o(a_busy), .done_o(a_done),
    .overflow_o(a_ovf), .instr_cnt_o(a_cnt)
  );

  dii_stream_ctrl #(.DEPTH(4), .RST_CYCLES(RST_CYC), .DRAIN_CYCLES(DRAIN_CYC), .NOP_WORD(NOP)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .load_valid_i(load_valid_i & use_b), .load_data_i(load_data_i), .load_ready_o(b_ready),
    .start_i(start_i & use_b), .clear_i(clear_i & use_b), .instr_ack_i(instr_ack_i & use_b),
    .instr_rdata_dii_o(b_rdata), .core_rst_n_o(b_crst), .busy_o(b_busy), .done_o(b_done),
    .overflow_o(b_ovf), .instr_cnt_o(b_cnt)
  );

  wire        o_ready = use_b ? b_ready : a_ready;
  wire        o_crst  = use_b ? b_crst  : a_crst;
  wire        o_busy  = use_b ? b_busy  : a_busy;
  wire        o_done  = use_b ? b_done  : a_done;
  wire        o_ovf   = use_b ? b_ovf   : a_ovf;
  wire [31:0] o_rdata = use_b ? b_rdata : a_rdata;
  wire [10:0] o_cnt   = use_b ? {8'b0, b_cnt} : a_cnt;

  // Reference model: the buffered stream and the sticky overflow flag.
  logic [31:0] stream_q[$];
  logic        ovf_m = 1'b0;
  int n_checks = 0;
  int n_errors = 0;

  function automatic int depth_m();
    return use_b ? 4 : 1024;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, o_ready, 1);
    check({tag, "_crst"}, o_crst, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_ovf"}, o_ovf, ovf_m);
    check({tag, "_cnt"}, o_cnt, 0);
    check({tag, "_rdata"}, o_rdata, NOP);
  endtask

  task automatic load_word(input logic [31:0] w);
    check("load_ready", o_ready, (stream_q.size() < depth_m()));
    load_valid_i = 1'b1;
    load_data_i  = w;
    @(negedge clk);
    load_valid_i = 1'b0;
    if (stream_q.size() < depth_m()) stream_q.push_back(w);
    else ovf_m = 1'b1;
    check("load_ovf", o_ovf, ovf_m);
  endtask

  // mode 1: ack every cycle; 3: ack every third cycle; otherwise random acks.
  task automatic run_stream(input int mode);
    int cyc;
    int k;
    int ph;
    int n;
    logic a;
    logic [31:0] exp_w[$];
    exp_w = stream_q;
    n = exp_w.size();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    while (o_crst === 1'b0 && cyc < 200) begin
      check("core_rst_busy", o_busy, 1);
      cyc++;
      @(negedge clk);
    end
    check("core_rst_cycles", cyc, RST_CYC);
    check("run_crst", o_crst, 1);
    if (n == 0) begin
      check("empty_word", o_rdata, NOP);
      check("empty_busy", o_busy, 1);
      @(negedge clk);
    end
    k = 0;
    ph = 0;
    cyc = 0;
    while (k < n && cyc < 400) begin
      check("run_word", o_rdata, exp_w[k]);
      check("run_cnt", o_cnt, k);
      check("run_busy", o_busy, 1);
      check("run_done", o_done, 0);
      if (mode == 1) a = 1'b1;
      else if (mode == 3) a = (ph == 2);
      else a = 1'($urandom_range(0, 1));
      ph = (ph == 2) ? 0 : ph + 1;
      instr_ack_i = a;
      start_i = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      instr_ack_i = 1'b0;
      start_i = 1'b0;
      if (a) k++;
      cyc++;
    end
    cyc = 0;
    while (o_done !== 1'b1 && cyc < 200) begin
      check("drain_word", o_rdata, NOP);
      check("drain_cnt", o_cnt, n);
      check("drain_busy", o_busy, 1);
      check("drain_crst", o_crst, 1);
      load_valid_i = 1'($urandom_range(0, 1));
      load_data_i  = $urandom;
      instr_ack_i  = 1'($urandom_range(0, 1));
      @(negedge clk);
      load_valid_i = 1'b0;
      instr_ack_i  = 1'b0;
      cyc++;
    end
    check("drain_cycles", cyc, DRAIN_CYC);
    instr_ack_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    instr_ack_i = 1'b0;
    start_i = 1'b0;
    check("done_done", o_done, 1);
    check("done_busy", o_busy, 0);
    check("done_cnt", o_cnt, n);
    check("done_rdata", o_rdata, NOP);
    check("done_crst", o_crst, 1);
    check("done_ready", o_ready, 0);
    check("done_ovf", o_ovf, ovf_m);
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    stream_q.delete();
    ovf_m = 1'b0;
    check_idle("clear");
  endtask

  initial begin
    int n;
    int cyc;
    #12;
    check_idle("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    load_word(32'h00000013);
    load_word(32'h00100093);
    load_word(32'h00208113);
    run_stream(1);
    do_clear();

    load_word(32'h00000013);
    load_word(32'h00100093);
    load_word(32'h00208113);
    run_stream(3);
    do_clear();

    run_stream(1);
    do_clear();

    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) load_word($urandom);
      run_stream(0);
      do_clear();
    end

    use_b = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) load_word(32'h00a00000 + i);
    check("b_ready_full", o_ready, 0);
    check("b_ovf_set", o_ovf, 1);
    run_stream(1);
    do_clear();
    run_stream(0);
    do_clear();
    use_b = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) load_word($urandom);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 0;
    while (o_crst === 1'b0 && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    check("mid_rst_run", o_crst, 1);
    instr_ack_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    instr_ack_i = 1'b0;
    check("mid_rst_cnt_before", o_cnt, 2);
    #2 rst_n = 1'b0;
    stream_q.delete();
    ovf_m = 1'b0;
    #1;
    check_idle("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_stream(1);
    do_clear();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dii_stream_ctrl.md
# dii_stream_ctrl

Sequencer for the Direct Instruction Injection (DII) path of the CHERIoT core bench. It buffers a loaded instruction stream and holds the core in reset for a fixed window. It then presents one instruction word per core acknowledge, pads with NOPs at end-of-stream, and waits a drain window before flagging completion. It sits between the stream loader and the core's `instr_rdata_dii` input, replacing free-running bench sequencing with a synthesizable controller.

## Interface
- `DEPTH`, 1024: stream buffer entries; power of two, at least 2.
- `RST_CYCLES`, 10: cycles `core_rst_n_o` is held low after start; at least 1.
- `DRAIN_CYCLES`, 10: cycles after end-of-stream before done; at least 1.
- `NOP_WORD`, 32'h1: word presented when no stream word is valid.
- `clk` input 1: clock, `clk`.
- `rst_n` input 1: reset `rst_n`, asynchronous, active-low.
- `load_valid_i` input 1: load word valid.
- `load_data_i` input 32: instruction word to append.
- `load_ready_o` output 1: buffer accepts a word this cycle.
- `start_i` input 1: begin a run (single-cycle pulse).
- `clear_i` input 1: return from DONE to IDLE and empty the buffer.
- `instr_ack_i` input 1: the core consumed the presented word.
- `instr_rdata_dii_o` output 32: word presented to the core.
- `core_rst_n_o` output 1: core reset, active-low.
- `busy_o` output 1: state is CORE_RST, RUN or DRAIN.
- `done_o` output 1: state is DONE.
- `overflow_o` output 1: sticky; a load was attempted while the buffer was full.
- `instr_cnt_o` output $clog2(DEPTH)+1: acknowledged stream words in the current run.

## Operation
- States:
  - IDLE → CORE_RST on `start_i`.
  - CORE_RST → RUN after `RST_CYCLES` cycles.
  - RUN → DRAIN when the last stream word is acked, or immediately when length is 0.
  - DRAIN → DONE after `DRAIN_CYCLES` cycles.
  - DONE → IDLE on `clear_i`.
- Load (IDLE only):
  - `load_ready_o` = (state==IDLE) && (len < DEPTH).
  - On `load_valid_i && load_ready_o`: `mem[len]` is written and `len` increments. `len` is $clog2(DEPTH)+1 bits and saturates at DEPTH.
  - `load_valid_i` while full in IDLE sets `overflow_o`, and the word is dropped.
  - `load_valid_i` outside IDLE is ignored; it does not set overflow.
- Start:
  - Effective only in IDLE. `len`, `mem` and `overflow_o` are retained.
  - The index `idx` and `instr_cnt_o` clear to 0.
  - `start_i` in any other state is ignored.
- CORE_RST:
  - `core_rst_n_o`=0 for exactly `RST_CYCLES` cycles.
  - On the transition to RUN, `instr_rdata_dii_o` loads `mem[0]`, or `NOP_WORD` if `len`==0.
- RUN, on `instr_ack_i`:
  - `idx` and `instr_cnt_o` increment.
  - `instr_rdata_dii_o` loads `mem[idx+1]` if idx+1 < len, else `NOP_WORD`, and the state goes to DRAIN.
- DRAIN/DONE:
  - `instr_rdata_dii_o`=`NOP_WORD`. Acks are ignored and `instr_cnt_o` is frozen.
  - `core_rst_n_o` stays 1.
- Clear:
  - Effective in DONE only.
  - `len`, `idx`, `instr_cnt_o` and `overflow_o` clear to 0; `mem` contents are don't-care.
- `instr_ack_i` outside RUN has no effect.

## Timing
- Reset values (async): state IDLE, `instr_rdata_dii_o`=`NOP_WORD`, `core_rst_n_o`=0, `load_ready_o`=1, `busy_o`=0, `done_o`=0, `overflow_o`=0, `instr_cnt_o`=0, `len`=0.
- `core_rst_n_o` is 0 in IDLE and CORE_RST, and 1 in RUN/DRAIN/DONE. It rises on the same edge that enters RUN.
- Start at edge T:
  - CORE_RST is entered at T+1.
  - RUN is entered at T+1+`RST_CYCLES`, with `mem[0]` valid on `instr_rdata_dii_o` from that edge.
- Ack at edge E: the next word is visible after E; one word is accepted per cycle, so back-to-back acks are legal.
- End-of-stream: the ack of word len-1 at edge E enters DRAIN at E+1. DONE is entered at E+1+`DRAIN_CYCLES`.
- Empty stream: RUN lasts exactly one cycle, then DRAIN.
- Outputs are all registered; no combinational path from inputs to outputs except `load_ready_o` (state and `len` only, registered sources).
- Mid-run `rst_n` assertion: immediate return to reset values. The buffer is lost (`len`=0).

## Test plan
- Load 3 words (0x00000013, 0x00100093, 0x00208113), then pulse `start_i`:
  - `core_rst_n_o` is low for exactly 10 cycles.
  - Then 0x00000013 is presented.
  - Ack every cycle → words appear in order, then 0x1.
  - `instr_cnt_o`=3; `done_o` rises 10 cycles after the third ack.
- Same stream with acks every third cycle → each word is held stable until its ack, and `instr_cnt_o` increments only on acks.
- Pulse `start_i` with `len`=0 → 0x1 on the output, RUN for 1 cycle, `done_o` after 10 DRAIN cycles, `instr_cnt_o`=0.
- With DEPTH=4, load 5 words:
  - `load_ready_o` drops after 4 and `overflow_o`=1.
  - The run presents 4 words, then 0x1.
- Pulse `start_i` during RUN and `load_valid_i` during DRAIN → both ignored. Then `clear_i` in DONE → IDLE, `len`=0, `overflow_o`=0, `load_ready_o`=1.
- Assert `rst_n` low mid-RUN → all outputs return to reset values within the same cycle; `core_rst_n_o`=0.
